wash_cycle_ctrl: RTL and testbench
==================================

Name: wash_cycle_ctrl

Overview:
- Top-level washing-machine sequencer.
- Walks a programme of IDLE → FILL → WASH → RINSE → SPIN → IDLE, with an optional second WASH/RINSE pass.
- Drives the existing timer block: loads `timer_period` per phase, restarts it, gates its enable, and advances the phase on `timer_done`.
- Drives the water valve, motors, drain and door lock.

Parameters:
- PW, 16, width of timer_period; must match the timer's period port.
- FILL_T, 2, FILL duration in timer units (seconds; the timer applies clk_freq).
- WASH_T, 5, WASH duration.
- RINSE_T, 2, RINSE duration.
- SPIN_T, 1, SPIN duration.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  coin/start level; sampled in IDLE only.
- double_wash  in  1  programme select; latched on the accepted start.
- door_closed  in  1  1 = door shut.
- pause  in  1  level; freezes the current timed phase.
- timer_done  in  1  from timer; phase time elapsed.
- timer_enable  out  1  to timer enable.
- timer_clear  out  1  one-cycle synchronous restart pulse to the timer.
- timer_period  out  PW  phase duration to the timer.
- water_valve  out  1  fill valve.
- wash_motor  out  1  agitate motor.
- spin_motor  out  1  spin motor.
- drain_pump  out  1  drain.
- door_lock  out  1  door latch.
- state  out  3  current phase: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4.
- done  out  1  one-cycle pulse at programme end.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE. All outputs 0, timer_period=0. Pass counter and latched double_wash cleared. Release is synchronous to clk.
- IDLE → FILL on the first clk edge where start=1 and door_closed=1.
  - On that edge: latch double_wash, clear the pass counter.
  - start with door_closed=0 is ignored; start is not remembered.
- Phase entry: on the edge that enters FILL, WASH, RINSE or SPIN, in the same registered update:
  - timer_clear=1 for exactly that one cycle.
  - timer_period = that phase's parameter, held stable for the whole phase.
- timer_enable = (state≠IDLE) & ~pause & ~timer_clear.
- timer_done is honoured only when timer_enable=1; at any other time it is ignored.
- Transitions, taken on the edge where honoured timer_done=1:
  - FILL → WASH.
  - WASH → RINSE.
  - RINSE → WASH if (latched double_wash & pass==0); set pass=1.
  - RINSE → SPIN otherwise.
  - SPIN → IDLE; done=1 for one cycle on that edge.
- Actuators are registered and decoded from the next state; all are 0 while pause=1:
  - water_valve=1 in FILL.
  - wash_motor=1 in WASH and RINSE.
  - drain_pump=1 in RINSE and SPIN.
  - spin_motor=1 in SPIN.
- door_lock=1 in every non-IDLE state, including while paused. It goes to 0 on the same edge the state returns to IDLE.
- Pause:
  - Holds state and pass counter; timer_enable=0, so the timer keeps its count.
  - Releasing pause resumes the same phase without a new timer_clear.
  - Pause asserted in IDLE has no effect.
- start, double_wash and door_closed are ignored outside IDLE. A new start during a cycle does not restart the programme.
- Simultaneous pause=1 and timer_done=1: pause wins; no transition occurs.
- Phase duration of 0: the timer's behaviour governs; the controller imposes no minimum.
- Reset mid-cycle: immediate return to IDLE with all actuators and door_lock at 0, and no done pulse.

Test Plan:
- Reset with reset=0 while in WASH → state=0 and all outputs 0 asynchronously (before the next clk edge); after release, state stays IDLE.
- start=1, door_closed=0 for 3 cycles → remains IDLE, door_lock=0. Then door_closed=1 → next edge state=1, timer_clear pulses once, timer_period=2, water_valve=1, door_lock=1.
- Single programme, timer_done pulsed once per phase → state sequence 1,2,3,4,0; timer_period sequence 2,5,2,1; one timer_clear per phase; done=1 exactly one cycle on return to IDLE.
- double_wash=1 at start → sequence 1,2,3,2,3,4,0 (WASH and RINSE twice). double_wash deasserted mid-cycle → sequence unchanged.
- pause=1 in WASH for 4 cycles with timer_done=1 during the pause → timer_enable=0, wash_motor=0, door_lock=1, state stays 2. Release pause → wash_motor=1, no timer_clear, state advances on the next timer_done.
- timer_done=1 in the same cycle as timer_clear on phase entry → ignored, state unchanged.

Source files
------------

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine programme sequencer: IDLE -> FILL -> WASH -> RINSE -> SPIN -> IDLE,
// with an optional second WASH/RINSE pass; drives the external phase timer and actuators.
module wash_cycle_ctrl #(
    parameter int unsigned PW      = 16,
    parameter int unsigned FILL_T  = 2,
    parameter int unsigned WASH_T  = 5,
    parameter int unsigned RINSE_T = 2,
    parameter int unsigned SPIN_T  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          double_wash,
    input  logic          door_closed,
    input  logic          pause,
    input  logic          timer_done,
    output logic          timer_enable,
    output logic          timer_clear,
    output logic [PW-1:0] timer_period,
    output logic          water_valve,
    output logic          wash_motor,
    output logic          spin_motor,
    output logic          drain_pump,
    output logic          door_lock,
    output logic [2:0]    state,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4
    } phase_t;

    phase_t        cur, nxt;
    logic          pass, nxt_pass;
    logic          dw, nxt_dw;
    logic          nxt_done;
    logic          entering;
    logic          honoured;
    logic [PW-1:0] nxt_period;

    // The restart cycle itself keeps the timer gated, so a stale done is never honoured.
    assign timer_enable = (cur != IDLE) & ~pause & ~timer_clear;
    assign honoured     = timer_enable & timer_done;
    assign state        = cur;

    always_comb begin
        nxt      = cur;
        nxt_pass = pass;
        nxt_dw   = dw;
        nxt_done = 1'b0;
        case (cur)
            IDLE: begin
                if (start && door_closed) begin
                    nxt      = FILL;
                    nxt_dw   = double_wash;
                    nxt_pass = 1'b0;
                end
            end
            FILL:  if (honoured) nxt = WASH;
            WASH:  if (honoured) nxt = RINSE;
            RINSE: begin
                if (honoured) begin
                    if (dw && !pass) begin
                        nxt      = WASH;
                        nxt_pass = 1'b1;
                    end else begin
                        nxt = SPIN;
                    end
                end
            end
            SPIN: begin
                if (honoured) begin
                    nxt      = IDLE;
                    nxt_done = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign entering = (nxt != cur) && (nxt != IDLE);

    always_comb begin
        nxt_period = timer_period;
        case (nxt)
            FILL:    nxt_period = PW'(FILL_T);
            WASH:    nxt_period = PW'(WASH_T);
            RINSE:   nxt_period = PW'(RINSE_T);
            SPIN:    nxt_period = PW'(SPIN_T);
            default: nxt_period = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur          <= IDLE;
            pass         <= 1'b0;
            dw           <= 1'b0;
            timer_clear  <= 1'b0;
            timer_period <= '0;
            water_valve  <= 1'b0;
            wash_motor   <= 1'b0;
            spin_motor   <= 1'b0;
            drain_pump   <= 1'b0;
            door_lock    <= 1'b0;
            done         <= 1'b0;
        end else begin
            cur          <= nxt;
            pass         <= nxt_pass;
            dw           <= nxt_dw;
            timer_clear  <= entering;
            timer_period <= nxt_period;
            water_valve  <= (nxt == FILL) & ~pause;
            wash_motor   <= ((nxt == WASH) | (nxt == RINSE)) & ~pause;
            drain_pump   <= ((nxt == RINSE) | (nxt == SPIN)) & ~pause;
            spin_motor   <= (nxt == SPIN) & ~pause;
            door_lock    <= (nxt != IDLE);
            done         <= nxt_done;
        end
    end

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed vector bench for wash_cycle_ctrl: one table row per clock, plus reset sequences.
module tb_wash_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, double_wash, door_closed, pause, timer_done;
    logic        timer_enable, timer_clear;
    logic [15:0] timer_period;
    logic        water_valve, wash_motor, spin_motor, drain_pump, door_lock, done;
    logic [2:0]  state;

    int vectors = 0;
    int miscompares = 0;

    wash_cycle_ctrl #(.PW(16), .FILL_T(2), .WASH_T(5), .RINSE_T(2), .SPIN_T(1)) dut (
        .clk(clk), .reset(reset), .start(start), .double_wash(double_wash),
        .door_closed(door_closed), .pause(pause), .timer_done(timer_done),
        .timer_enable(timer_enable), .timer_clear(timer_clear), .timer_period(timer_period),
        .water_valve(water_valve), .wash_motor(wash_motor), .spin_motor(spin_motor),
        .drain_pump(drain_pump), .door_lock(door_lock), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    // inputs {start, double_wash, door_closed, pause, timer_done}
    // act    {timer_enable, water_valve, wash_motor, spin_motor, drain_pump, door_lock, done}
    typedef struct {
        logic [4:0]  in;
        logic [2:0]  st;
        logic        clr;
        logic [15:0] per;
        logic [6:0]  act;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic [4:0] in, input logic [2:0] st, input logic clr,
                               input logic [15:0] per, input logic [6:0] act);
        vec_t r;
        r.in = in; r.st = st; r.clr = clr; r.per = per; r.act = act;
        return r;
    endfunction

    function automatic logic [26:0] observed();
        return {state, timer_clear, timer_period, timer_enable, water_valve, wash_motor,
                spin_motor, drain_pump, door_lock, done};
    endfunction

    task automatic check(input string name, input logic [26:0] exp);
        logic [26:0] got;
        got = observed();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got state=%0d clr=%0b per=%0d en/wv/wm/sm/dp/lk/dn=%07b, want state=%0d clr=%0b per=%0d en/wv/wm/sm/dp/lk/dn=%07b",
                     name, got[26:24], got[23], got[22:7], got[6:0],
                     exp[26:24], exp[23], exp[22:7], exp[6:0]);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {start, double_wash, door_closed, pause, timer_done} = in;
    endtask

    initial begin
        // door open: start ignored
        repeat (3) vecs.push_back(v(5'b10000, 0, 0, 0, 7'b0000000));
        // single programme; timer_done during entry-clear cycle is ignored
        vecs.push_back(v(5'b10100, 1, 1, 2, 7'b0100010));
        vecs.push_back(v(5'b00001, 1, 0, 2, 7'b1100010));
        vecs.push_back(v(5'b00001, 2, 1, 5, 7'b0010010));
        vecs.push_back(v(5'b00000, 2, 0, 5, 7'b1010010));
        vecs.push_back(v(5'b00001, 3, 1, 2, 7'b0010110));
        vecs.push_back(v(5'b10100, 3, 0, 2, 7'b1010110));
        vecs.push_back(v(5'b00001, 4, 1, 1, 7'b0001110));
        vecs.push_back(v(5'b00000, 4, 0, 1, 7'b1001110));
        vecs.push_back(v(5'b00001, 0, 0, 0, 7'b0000001));
        vecs.push_back(v(5'b00000, 0, 0, 0, 7'b0000000));
        // double wash, double_wash dropped mid-cycle, pause in second WASH
        vecs.push_back(v(5'b11100, 1, 1, 2, 7'b0100010));
        vecs.push_back(v(5'b00000, 1, 0, 2, 7'b1100010));
        vecs.push_back(v(5'b00001, 2, 1, 5, 7'b0010010));
        vecs.push_back(v(5'b00001, 2, 0, 5, 7'b1010010));
        vecs.push_back(v(5'b00001, 3, 1, 2, 7'b0010110));
        vecs.push_back(v(5'b00000, 3, 0, 2, 7'b1010110));
        vecs.push_back(v(5'b00001, 2, 1, 5, 7'b0010010));
        vecs.push_back(v(5'b00000, 2, 0, 5, 7'b1010010));
        repeat (4) vecs.push_back(v(5'b00011, 2, 0, 5, 7'b0000010));
        vecs.push_back(v(5'b00000, 2, 0, 5, 7'b1010010));
        vecs.push_back(v(5'b00001, 3, 1, 2, 7'b0010110));
        vecs.push_back(v(5'b00000, 3, 0, 2, 7'b1010110));
        vecs.push_back(v(5'b00001, 4, 1, 1, 7'b0001110));
        vecs.push_back(v(5'b00000, 4, 0, 1, 7'b1001110));
        vecs.push_back(v(5'b00001, 0, 0, 0, 7'b0000001));
        // pause in IDLE does not block start; valve gated while paused
        vecs.push_back(v(5'b00010, 0, 0, 0, 7'b0000000));
        vecs.push_back(v(5'b10110, 1, 1, 2, 7'b0000010));
        vecs.push_back(v(5'b00000, 1, 0, 2, 7'b1100010));
        vecs.push_back(v(5'b00001, 2, 1, 5, 7'b0010010));
        vecs.push_back(v(5'b00000, 2, 0, 5, 7'b1010010));

        reset = 1'b0;
        drive(5'b00000);
        repeat (2) @(negedge clk);
        check("reset_state", '0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {vecs[i].st, vecs[i].clr, vecs[i].per, vecs[i].act});
        end

        // asynchronous reset while in WASH, observed before any clock edge
        #1 reset = 1'b0;
        #1 check("async_reset_mid_wash", '0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", i), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
